// File: rtl/phy_init_pkg.sv
// Shared types and constants for the PHY MDIO init sequencer: state encoding,
// clause-22 frame fields and the fixed register write table.
package phy_init_pkg;

  typedef enum logic [2:0] {
    RST_ASSERT,
    RST_WAIT,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } init_state_e;

  localparam int         NUM_WRITES = 3;
  localparam logic [1:0] ST         = 2'b01;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] TA         = 2'b10;

  typedef struct packed {
    logic [4:0]  regad;
    logic [15:0] data;
  } mdio_write_t;

  function automatic mdio_write_t write_entry(input logic [1:0] idx);
    mdio_write_t w;
    case (idx)
      2'd0:    w = '{regad: 5'h00, data: 16'h1140};
      2'd1:    w = '{regad: 5'h04, data: 16'h01E1};
      default: w = '{regad: 5'h09, data: 16'h0200};
    endcase
    return w;
  endfunction

  // 32-bit preamble of ones, then ST, OP, PHYAD, REGAD, TA, DATA, MSB first.
  function automatic logic [63:0] build_frame(input logic [4:0] phy, input mdio_write_t w);
    return {32'hFFFF_FFFF, ST, OP_WRITE, phy, w.regad, TA, w.data};
  endfunction

endpackage

// File: rtl/mdio_frame_tx.sv
// MDC divider and 64-bit MDIO shifter; emits one write frame per start pulse.
module mdio_frame_tx #(
  parameter int MDC_DIV = 25
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] frame,
  output logic        busy,
  output logic        mdio_scl,
  output logic        mdio_sda,
  output logic        last
);

  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [63:0] shreg;
  logic        half_hi;
  logic        half_end;

  assign half_end = (div_cnt == 8'(MDC_DIV - 1));
  // High on the final clock of the frame, so the sequencer leaves SHIFT as busy drops.
  assign last     = busy & half_end & half_hi & (bit_cnt == 6'd63);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy     <= 1'b0;
      mdio_scl <= 1'b0;
      mdio_sda <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      half_hi  <= 1'b0;
    end else if (abort) begin
      busy     <= 1'b0;
      mdio_scl <= 1'b0;
      mdio_sda <= 1'b1;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      half_hi  <= 1'b0;
    end else if (start) begin
      busy     <= 1'b1;
      mdio_scl <= 1'b0;
      mdio_sda <= frame[63];
      shreg    <= {frame[62:0], 1'b0};
      div_cnt  <= '0;
      bit_cnt  <= '0;
      half_hi  <= 1'b0;
    end else if (busy) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 1'b1;
      end else begin
        div_cnt <= '0;
        if (!half_hi) begin
          half_hi  <= 1'b1;
          mdio_scl <= 1'b1;
        end else if (bit_cnt == 6'd63) begin
          busy     <= 1'b0;
          half_hi  <= 1'b0;
          mdio_scl <= 1'b0;
          mdio_sda <= 1'b1;
        end else begin
          // Data moves on the falling MDC edge, stable through the high half.
          half_hi  <= 1'b0;
          mdio_scl <= 1'b0;
          mdio_sda <= shreg[63];
          shreg    <= {shreg[62:0], 1'b0};
          bit_cnt  <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_mdio_init.sv
// PHY bring-up sequencer: hardware reset pulse, settle wait, then a fixed
// table of MDIO register writes; flags completion to gate the MAC reset.
module phy_mdio_init
  import phy_init_pkg::*;
#(
  parameter int         MDC_DIV      = 25,
  parameter int         RESET_CYCLES = 1250000,
  parameter int         WAIT_CYCLES  = 2500000,
  parameter logic [4:0] PHY_ADDR     = 5'd0
) (
  input  logic clock,
  input  logic resetn,
  input  logic restart,
  output logic phy_resetn,
  output logic mdio_scl,
  output logic mdio_sda,
  output logic phy_init_done,
  output logic busy
);

  localparam int MAX_RW  = (RESET_CYCLES > WAIT_CYCLES) ? RESET_CYCLES : WAIT_CYCLES;
  localparam int MAX_ALL = (MAX_RW > 2 * MDC_DIV) ? MAX_RW : 2 * MDC_DIV;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] R_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] W_LAST   = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * MDC_DIV - 1);
  // Between frames the LOAD clock is the last idle clock of the gap.
  localparam logic [CW-1:0] GAP_PRE  = CW'(2 * MDC_DIV - 2);
  localparam logic [1:0]    LAST_IDX = 2'(NUM_WRITES - 1);

  init_state_e   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic          tx_start;
  logic          tx_last;
  logic [63:0]   frame;

  assign frame = build_frame(PHY_ADDR, write_entry(idx));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RST_ASSERT;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    idx_n    = idx;
    tx_start = 1'b0;
    if (restart) begin
      state_n = RST_ASSERT;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        RST_ASSERT: if (cnt == R_LAST) begin
          state_n = RST_WAIT;
          cnt_n   = '0;
        end
        RST_WAIT: if (cnt == W_LAST) begin
          state_n = LOAD;
          cnt_n   = '0;
          idx_n   = '0;
        end
        LOAD: begin
          tx_start = 1'b1;
          state_n  = SHIFT;
          cnt_n    = '0;
        end
        SHIFT: begin
          cnt_n = '0;
          if (tx_last) state_n = GAP;
        end
        GAP: begin
          if (idx == LAST_IDX) begin
            if (cnt == GAP_LAST) begin
              state_n = DONE;
              cnt_n   = '0;
            end
          end else if (cnt == GAP_PRE) begin
            state_n = LOAD;
            cnt_n   = '0;
            idx_n   = idx + 1'b1;
          end
        end
        DONE:    cnt_n = '0;
        default: begin
          state_n = RST_ASSERT;
          cnt_n   = '0;
          idx_n   = '0;
        end
      endcase
    end
  end

  assign phy_resetn    = (state != RST_ASSERT);
  assign phy_init_done = (state == DONE);

  mdio_frame_tx #(.MDC_DIV(MDC_DIV)) u_tx (
    .clock   (clock),
    .resetn  (resetn),
    .start   (tx_start),
    .abort   (restart),
    .frame   (frame),
    .busy    (busy),
    .mdio_scl(mdio_scl),
    .mdio_sda(mdio_sda),
    .last    (tx_last)
  );

endmodule

// File: tb/tb_phy_mdio_init.sv
// Directed bench for phy_mdio_init with short reset/wait counts and MDC_DIV=2.
module tb_phy_mdio_init;

  logic clock = 1'b0;
  logic resetn, restart;
  logic phy_resetn, mdio_scl, mdio_sda, phy_init_done, busy;

  int checks = 0;
  int errors = 0;

  phy_mdio_init #(
    .MDC_DIV(2), .RESET_CYCLES(10), .WAIT_CYCLES(20), .PHY_ADDR(5'd1)
  ) dut (
    .clock(clock), .resetn(resetn), .restart(restart),
    .phy_resetn(phy_resetn), .mdio_scl(mdio_scl), .mdio_sda(mdio_sda),
    .phy_init_done(phy_init_done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [11];
  logic [63:0] got  [11];
  bit          timed_out;

  task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, g, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Follows one full init run starting at the clock after reset/restart release.
  // got: 0 reset width, 1 first MDC rise, 2-4 busy widths, 5-6 gaps, 7 done delay, 8-10 frames.
  task automatic measure(input int budget);
    int n = 0, rise_at = -1, busy_at = 0, fall_at = 0, fi = 0, nb = 0, nfr = 0;
    logic pscl, pbusy, pdone;
    logic [63:0] sh = '0;
    for (int k = 0; k < 11; k++) got[k] = '1;
    pscl = mdio_scl; pbusy = busy; pdone = phy_init_done;
    timed_out = 1'b1;
    while (n < budget) begin
      tick();
      n++;
      if (rise_at < 0 && phy_resetn) begin
        rise_at = n;
        got[0]  = 64'(n);
      end
      if (mdio_scl && !pscl) begin
        if (got[1] == '1 && rise_at >= 0) got[1] = 64'(n - rise_at);
        sh = {sh[62:0], mdio_sda};
        nb++;
        if (nb == 64) begin
          if (fi < 3) got[8+fi] = sh;
          fi++;
          nb = 0;
        end
      end
      if (busy && !pbusy) begin
        if (nfr >= 1 && nfr <= 2) got[4+nfr] = 64'(n - fall_at);
        busy_at = n;
      end
      if (!busy && pbusy) begin
        if (nfr < 3) got[2+nfr] = 64'(n - busy_at);
        fall_at = n;
        nfr++;
      end
      if (phy_init_done && !pdone) begin
        got[7]    = 64'(n - fall_at);
        timed_out = 1'b0;
        break;
      end
      pscl = mdio_scl; pbusy = busy; pdone = phy_init_done;
    end
  endtask

  task automatic run_table(input string tag);
    measure(3000);
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
    for (int i = 0; i < 11; i++) chk({tag, "_", vecs[i].name}, got[i], vecs[i].exp);
  endtask

  // Steps until nbits MDC rises into frame number frame_no (1-based) of the current run.
  task automatic wait_frame_bit(input int frame_no, input int nbits);
    int n = 0, frames = 0, bits = 0;
    logic pscl = mdio_scl, pbusy = busy;
    bit ok = 1'b0;
    while (n < 3000 && !ok) begin
      tick();
      n++;
      if (busy && !pbusy) begin frames++; bits = 0; end
      if (mdio_scl && !pscl && frames == frame_no) bits++;
      if (frames == frame_no && bits == nbits) ok = 1'b1;
      pscl = mdio_scl; pbusy = busy;
    end
    if (!ok) chk("wait_frame_bit_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    int bad;
    // ST=01 OP=01 PHYAD=00001 REGAD TA=10 DATA after the all-ones preamble.
    vecs[0]  = '{name: "rst_low",    exp: 64'd10};
    vecs[1]  = '{name: "first_rise", exp: 64'd23};
    vecs[2]  = '{name: "busy0",      exp: 64'd256};
    vecs[3]  = '{name: "busy1",      exp: 64'd256};
    vecs[4]  = '{name: "busy2",      exp: 64'd256};
    vecs[5]  = '{name: "gap0",       exp: 64'd4};
    vecs[6]  = '{name: "gap1",       exp: 64'd4};
    vecs[7]  = '{name: "done_dly",   exp: 64'd4};
    vecs[8]  = '{name: "frame0",     exp: 64'hFFFF_FFFF_5082_1140};
    vecs[9]  = '{name: "frame1",     exp: 64'hFFFF_FFFF_5092_01E1};
    vecs[10] = '{name: "frame2",     exp: 64'hFFFF_FFFF_50A6_0200};

    resetn  = 1'b0;
    restart = 1'b0;
    tick();
    tick();
    chk("rst_phy_resetn", 64'(phy_resetn), 64'd0);
    chk("rst_scl",        64'(mdio_scl), 64'd0);
    chk("rst_sda",        64'(mdio_sda), 64'd1);
    chk("rst_done",       64'(phy_init_done), 64'd0);
    chk("rst_busy",       64'(busy), 64'd0);
    resetn = 1'b1;
    run_table("run1");

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (mdio_scl !== 1'b0 || mdio_sda !== 1'b1 || phy_init_done !== 1'b1) bad++;
    end
    chk("done_hold_bad", 64'(bad), 64'd0);

    // Restart from DONE, then abandon frame 2 at bit 40.
    pulse_restart();
    chk("rs_done_clear", 64'(phy_init_done), 64'd0);
    wait_frame_bit(2, 40);
    chk("rs_pre_busy", 64'(busy), 64'd1);
    pulse_restart();
    chk("rs_phy_resetn", 64'(phy_resetn), 64'd0);
    chk("rs_busy",       64'(busy), 64'd0);
    chk("rs_done",       64'(phy_init_done), 64'd0);
    chk("rs_scl",        64'(mdio_scl), 64'd0);
    chk("rs_sda",        64'(mdio_sda), 64'd1);
    run_table("run2");

    // Repeated restart partway through the reset pulse restarts its count.
    pulse_restart();
    for (int i = 0; i < 7; i++) tick();
    chk("rr_still_low", 64'(phy_resetn), 64'd0);
    restart = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    restart = 1'b0;
    run_table("run3");

    // Async reset for one clock inside the settle wait.
    pulse_restart();
    for (int i = 0; i < 15; i++) tick();
    chk("ar_in_wait", 64'(phy_resetn), 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_phy_resetn", 64'(phy_resetn), 64'd0);
    chk("ar_scl",        64'(mdio_scl), 64'd0);
    chk("ar_sda",        64'(mdio_sda), 64'd1);
    chk("ar_done",       64'(phy_init_done), 64'd0);
    chk("ar_busy",       64'(busy), 64'd0);
    tick();
    resetn = 1'b1;
    run_table("run4");

    // Async reset mid-frame truncates the shift at once.
    pulse_restart();
    wait_frame_bit(1, 20);
    #2 resetn = 1'b0;
    #1;
    chk("mf_busy",       64'(busy), 64'd0);
    chk("mf_scl",        64'(mdio_scl), 64'd0);
    chk("mf_sda",        64'(mdio_sda), 64'd1);
    chk("mf_phy_resetn", 64'(phy_resetn), 64'd0);
    tick();
    resetn = 1'b1;
    run_table("run5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
